// File: rtl/program_loader.sv
// Byte-serial loader for the 8-entry instruction store: packs host bytes MSB-first
// into 32-bit words, writes them to RAM, and holds the processor until a full program is present.
module program_loader #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_instr,
    output logic              cpu_hold,
    output logic              load_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [1:0]          byte_cnt;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [WORD_W-9:0]   shift;
    logic [WORD_W-1:0]   mem [DEPTH];

    logic accept;
    logic word_wr;
    logic last_word;

    // Handshake: a byte transfers on a rising edge where in_valid and in_ready are both 1;
    // the host holds in_data stable while in_valid is high and in_ready is low.
    assign accept    = in_valid & in_ready;
    assign word_wr   = accept && (byte_cnt == 2'd3);
    assign last_word = word_wr && (wr_ptr == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = LOAD;
            LOAD:    if (last_word) state_next = DONE;
            DONE:    if (start)     state_next = LOAD;
            default:                state_next = IDLE;
        endcase
    end

    // Decodes of the state register, so they change the cycle after each transition.
    assign in_ready  = (state == LOAD);
    assign cpu_hold  = (state != DONE);
    assign load_done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            wr_ptr   <= '0;
            shift    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state != LOAD) begin
            if (start) begin
                byte_cnt <= '0;
                wr_ptr   <= '0;
            end
        end else if (accept) begin
            shift    <= {shift[WORD_W-17:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (word_wr) begin
                mem[wr_ptr] <= {shift, in_data};
                wr_ptr      <= last_word ? '0 : wr_ptr + ADDR_W'(1);
            end
        end
    end

    // Combinational read in every state; a same-edge write shows up from the next cycle.
    assign rd_instr = mem[rd_addr];

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset state, packing, gaps, reload,
// mid-load reset and start-with-valid collision.
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  rd_addr;
    logic [31:0] rd_instr;
    logic        cpu_hold;
    logic        load_done;

    int tests_run;
    int tests_failed;

    program_loader #(.DEPTH(8), .ADDR_W(3), .WORD_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rd_addr   (rd_addr),
        .rd_instr  (rd_instr),
        .cpu_hold  (cpu_hold),
        .load_done (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents one byte and waits (bounded) until it is accepted.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 20 && !got; k++) begin
            if (in_ready) got = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL send_byte_timeout: in_ready=%0b required=1 for byte %02h", in_ready, b);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        repeat (3) tick();
        tests_run++;
        if ({cpu_hold, load_done, in_ready} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_flags: hold/done/ready=%03b required=100", {cpu_hold, load_done, in_ready});
        end
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            tests_run++;
            if (rd_instr !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_mem[%0d]: got %08h required 00000000", a, rd_instr);
            end
        end
    endtask

    task automatic test_load();
        logic [31:0] exp;
        pulse_start();
        tests_run++;
        if ({cpu_hold, load_done, in_ready} !== 3'b101) begin
            tests_failed++;
            $display("FAIL load_enter_flags: hold/done/ready=%03b required=101", {cpu_hold, load_done, in_ready});
        end
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i));
            if (i == 30) begin
                tests_run++;
                if (load_done !== 1'b0 || cpu_hold !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL load_early_done: done=%0b hold=%0b required done=0 hold=1", load_done, cpu_hold);
                end
            end
        end
        tests_run++;
        if ({cpu_hold, load_done, in_ready} !== 3'b010) begin
            tests_failed++;
            $display("FAIL load_done_flags: hold/done/ready=%03b required=010", {cpu_hold, load_done, in_ready});
        end
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            exp = {8'(4*a), 8'(4*a+1), 8'(4*a+2), 8'(4*a+3)};
            #1;
            tests_run++;
            if (rd_instr !== exp) begin
                tests_failed++;
                $display("FAIL load_mem[%0d]: got %08h required %08h", a, rd_instr, exp);
            end
        end
    endtask

    task automatic test_gaps();
        logic [31:0] exp;
        apply_reset();
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i));
            if (i == 1 || i == 12) repeat (3) tick();
        end
        tests_run++;
        if (load_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL gaps_done: load_done=%0b required=1", load_done);
        end
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            exp = {8'(4*a), 8'(4*a+1), 8'(4*a+2), 8'(4*a+3)};
            #1;
            tests_run++;
            if (rd_instr !== exp) begin
                tests_failed++;
                $display("FAIL gaps_mem[%0d]: got %08h required %08h", a, rd_instr, exp);
            end
        end
    endtask

    task automatic test_reload();
        tests_run++;
        if (cpu_hold !== 1'b0) begin
            tests_failed++;
            $display("FAIL reload_pre_hold: cpu_hold=%0b required=0", cpu_hold);
        end
        pulse_start();
        tests_run++;
        if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reload_hold: hold=%0b done=%0b required hold=1 done=0", cpu_hold, load_done);
        end
        rd_addr = 3'd0;
        for (int i = 0; i < 3; i++) send_byte(8'hA5);
        // 4th byte: word 0 old before the edge, new after it
        #1;
        tests_run++;
        if (rd_instr !== 32'h00010203) begin
            tests_failed++;
            $display("FAIL reload_rdw_old: got %08h required 00010203", rd_instr);
        end
        send_byte(8'hA5);
        tests_run++;
        if (rd_instr !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("FAIL reload_mem0: got %08h required A5A5A5A5", rd_instr);
        end
        rd_addr = 3'd1;
        #1;
        tests_run++;
        if (rd_instr !== 32'h04050607) begin
            tests_failed++;
            $display("FAIL reload_mem1_stale: got %08h required 04050607", rd_instr);
        end
        for (int i = 4; i < 32; i++) send_byte(8'hA5);
        tests_run++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
            tests_failed++;
            $display("FAIL reload_done: done=%0b hold=%0b required done=1 hold=0", load_done, cpu_hold);
        end
        rd_addr = 3'd7;
        #1;
        tests_run++;
        if (rd_instr !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("FAIL reload_mem7: got %08h required A5A5A5A5", rd_instr);
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(8'h80 + 8'(i));
        rst = 1'b1;
        #1;
        tests_run++;
        if ({cpu_hold, load_done, in_ready} !== 3'b100) begin
            tests_failed++;
            $display("FAIL midrst_flags: hold/done/ready=%03b required=100", {cpu_hold, load_done, in_ready});
        end
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            tests_run++;
            if (rd_instr !== 32'h0) begin
                tests_failed++;
                $display("FAIL midrst_mem[%0d]: got %08h required 00000000", a, rd_instr);
            end
        end
        tick();
        rst = 1'b0;
        tick();
        pulse_start();
        for (int i = 0; i < 32; i++) send_byte(8'h40 + 8'(i));
        rd_addr = 3'd0;
        #1;
        tests_run++;
        if (rd_instr !== 32'h40414243) begin
            tests_failed++;
            $display("FAIL midrst_restart_mem0: got %08h required 40414243", rd_instr);
        end
        rd_addr = 3'd7;
        #1;
        tests_run++;
        if (rd_instr !== 32'h5C5D5E5F) begin
            tests_failed++;
            $display("FAIL midrst_restart_mem7: got %08h required 5C5D5E5F", rd_instr);
        end
    endtask

    task automatic test_start_with_valid();
        apply_reset();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL startvalid_ready: in_ready=%0b required=0", in_ready);
        end
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        rd_addr = 3'd0;
        #1;
        tests_run++;
        if (rd_instr !== 32'h11223344) begin
            tests_failed++;
            $display("FAIL startvalid_mem0: got %08h required 11223344", rd_instr);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        rd_addr  = 3'd0;
        test_reset();
        test_load();
        test_gaps();
        test_reload();
        test_reset_mid_load();
        test_start_with_valid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
